hazard_scoreboard: RTL

//  Parametrised hazard/forwarding unit for the in-order MIPS pipeline, generalising the fixed two-stage EX/MEM scheme.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/hazard_match.sv | 42 ++++
 rtl/hazard_scoreboard.sv | 117 +++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard: one tracked pipeline entry and its readiness rule.
package hazard_pkg;

    // Entry fields are sized for the deepest supported pipeline so every instance shares one type.
    localparam int SB_MAX_DEPTH = 16;
    localparam int LAT_W        = $clog2(SB_MAX_DEPTH);
    localparam int SB_REG_W     = 5;

    typedef struct packed {
        logic                valid;
        logic [SB_REG_W-1:0] rd;
        logic [LAT_W-1:0]    lat;
    } sb_entry_t;

    // A result leaving stage k is usable once k has reached the producer's latency.
    function automatic logic is_ready(input int unsigned k, input logic [LAT_W-1:0] lat);
        return k >= 32'(lat);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Per-operand lookup: finds the youngest in-flight producer of src and reports
// whether its result can be forwarded yet.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int REG_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic [REG_W-1:0]        src_i,
    input  sb_entry_t [DEPTH-1:0]   entries_i,
    input  logic [DEPTH*DATA_W-1:0] stage_data_i,
    output logic                    hit_ready_o,
    output logic                    hit_unready_o,
    output logic [DATA_W-1:0]       data_o
);

    logic [SB_REG_W-1:0] src_ext;
    assign src_ext = SB_REG_W'(src_i);

    // Scan oldest to youngest so the youngest match overwrites any older one,
    // including an older ready match hidden behind a younger unready producer.
    always_comb begin
        hit_ready_o   = 1'b0;
        hit_unready_o = 1'b0;
        data_o        = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (src_ext != '0 && entries_i[k].valid && entries_i[k].rd == src_ext) begin
                if (is_ready(unsigned'(k), entries_i[k].lat)) begin
                    hit_ready_o   = 1'b1;
                    hit_unready_o = 1'b0;
                    data_o        = stage_data_i[k*DATA_W +: DATA_W];
                end else begin
                    hit_ready_o   = 1'b0;
                    hit_unready_o = 1'b1;
                    data_o        = '0;
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding unit: tracks destination registers of DEPTH post-decode stages,
// forwards ready results to decode and stalls F/D on unready producers or memory hold.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 1,
    parameter int REG_W    = 5,
    parameter int DATA_W   = 32,
    parameter int STAT_W   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    issue_valid_i,
    input  logic                    flush_i,
    input  logic [REG_W-1:0]        rs_i,
    input  logic [REG_W-1:0]        rt_i,
    input  logic [REG_W-1:0]        rd_i,
    input  logic                    is_load_i,
    input  logic                    mem_wait_i,
    input  logic [DEPTH*DATA_W-1:0] stage_data_i,
    output logic                    stall_o,
    output logic                    fwd_s_en_o,
    output logic [DATA_W-1:0]       fwd_s_data_o,
    output logic                    fwd_t_en_o,
    output logic [DATA_W-1:0]       fwd_t_data_o,
    output logic [STAT_W-1:0]       stall_cnt_o,
    output logic [DEPTH-1:0]        dbg_valid_o
);

    if (DEPTH < 1 || DEPTH > SB_MAX_DEPTH) begin : g_bad_depth
        $error("hazard_scoreboard: DEPTH out of range");
    end
    if (LOAD_LAT < 0 || LOAD_LAT >= DEPTH) begin : g_bad_lat
        $error("hazard_scoreboard: LOAD_LAT must be below DEPTH");
    end
    if (REG_W > SB_REG_W) begin : g_bad_regw
        $error("hazard_scoreboard: REG_W wider than entry rd field");
    end

    sb_entry_t [DEPTH-1:0] entry_q, entry_d;
    sb_entry_t             new_entry;
    logic [STAT_W-1:0]     stall_cnt_q, stall_cnt_d;

    logic                  s_ready, s_unready, t_ready, t_unready;
    logic [DATA_W-1:0]     s_data, t_data;
    logic                  hazard, hazard_stall, stall_raw;

    hazard_match #(.DEPTH(DEPTH), .REG_W(REG_W), .DATA_W(DATA_W)) u_match_s (
        .src_i        (rs_i),
        .entries_i    (entry_q),
        .stage_data_i (stage_data_i),
        .hit_ready_o  (s_ready),
        .hit_unready_o(s_unready),
        .data_o       (s_data)
    );

    hazard_match #(.DEPTH(DEPTH), .REG_W(REG_W), .DATA_W(DATA_W)) u_match_t (
        .src_i        (rt_i),
        .entries_i    (entry_q),
        .stage_data_i (stage_data_i),
        .hit_ready_o  (t_ready),
        .hit_unready_o(t_unready),
        .data_o       (t_data)
    );

    // A flushed slot never needs its operands, so it cannot cause a hazard stall.
    assign hazard       = s_unready | t_unready;
    assign hazard_stall = hazard & issue_valid_i & ~flush_i;
    assign stall_raw    = mem_wait_i | hazard_stall;

    always_comb begin
        new_entry.valid = (rd_i != '0);
        new_entry.rd    = SB_REG_W'(rd_i);
        new_entry.lat   = is_load_i ? LAT_W'(LOAD_LAT) : '0;
    end

    always_comb begin
        entry_d = entry_q;
        if (!mem_wait_i) begin
            for (int k = 1; k < DEPTH; k++) begin
                entry_d[k] = entry_q[k-1];
            end
            entry_d[0] = (hazard_stall || flush_i || !issue_valid_i) ? '0 : new_entry;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_raw && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            entry_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            entry_q     <= entry_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Decode-facing outputs are quiet while reset is held.
    assign stall_o      = ~reset & stall_raw;
    assign fwd_s_en_o   = ~reset & s_ready;
    assign fwd_t_en_o   = ~reset & t_ready;
    assign fwd_s_data_o = reset ? '0 : s_data;
    assign fwd_t_data_o = reset ? '0 : t_data;
    assign stall_cnt_o  = stall_cnt_q;

    for (genvar k = 0; k < DEPTH; k++) begin : g_dbg
        assign dbg_valid_o[k] = entry_q[k].valid;
    end

endmodule
